// File: rtl/mem_access_unit.sv
// Variable-latency memory stage: branch resolve, SB_DEPTH-entry store buffer draining in the
// background, loads over a req/ack port. Define STORE_FWD_EN to enable store-to-load forwarding.
module mem_access_unit #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [3:0]        xfer_size,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              zero,
    input  logic              branch,
    input  logic              cbz,
    input  logic              cbnz,
    output logic              BrTaken,
    output logic              stall,
    output logic              misalign,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ST_BUSY, S_LD_BUSY, S_LD_DONE} state_t;

    function automatic logic [DATA_W-1:0] mask_size(input logic [DATA_W-1:0] d,
                                                     input logic [3:0] s);
        case (s)
            4'd1:    mask_size = d & DATA_W'(64'h0000_0000_0000_00FF);
            4'd2:    mask_size = d & DATA_W'(64'h0000_0000_0000_FFFF);
            4'd4:    mask_size = d & DATA_W'(64'h0000_0000_FFFF_FFFF);
            default: mask_size = d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a, input logic [3:0] s);
        case (s)
            4'd1:    is_misaligned = 1'b0;
            4'd2:    is_misaligned = a[0];
            4'd4:    is_misaligned = |a[1:0];
            4'd8:    is_misaligned = |a[2:0];
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic              r_load_valid;
    logic [DATA_W-1:0] r_load_data;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_size;

    logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
    logic [3:0]        r_sb_size [SB_DEPTH];

    logic w_full, w_st_req, w_st_acc, w_ld_req, w_st_pop, w_ld_elig, w_ld_issue, w_fwd_go;
    logic [DATA_W-1:0] w_fwd_data;

    assign BrTaken  = branch | (cbz & zero) | (cbnz & ~zero);
    assign misalign = req_valid & is_misaligned(address, xfer_size);
    assign w_full   = (r_count == CNT_W'(SB_DEPTH));
    assign w_st_req = req_valid & req_write & ~misalign;
    assign w_st_acc = w_st_req & ~w_full;
    assign w_ld_req = req_valid & ~req_write & ~misalign;
    assign w_st_pop = (r_state == S_ST_BUSY) & mem_ack;
    // r_load_valid marks the cycle in which the presented load is consumed
    assign stall    = (w_st_req & w_full) | (w_ld_req & ~r_load_valid);

`ifdef STORE_FWD_EN
    logic              w_any_ovl;
    logic              w_fwd_hit;
    logic [PTR_W-1:0]  w_idx;
    logic [ADDR_W:0]   w_e_lo, w_e_hi, w_l_lo, w_l_hi;

    // Scan oldest to youngest so the last overlapping entry decides the hit
    always_comb begin
        w_any_ovl  = 1'b0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        w_e_lo     = '0;
        w_e_hi     = '0;
        w_l_lo     = {1'b0, address};
        w_l_hi     = {1'b0, address} + (ADDR_W+1)'(xfer_size);
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_idx  = r_head + PTR_W'(i);
            w_e_lo = {1'b0, r_sb_addr[w_idx]};
            w_e_hi = {1'b0, r_sb_addr[w_idx]} + (ADDR_W+1)'(r_sb_size[w_idx]);
            if ((CNT_W'(i) < r_count) && (w_e_lo < w_l_hi) && (w_l_lo < w_e_hi)) begin
                w_any_ovl  = 1'b1;
                w_fwd_hit  = (r_sb_addr[w_idx] == address) && (r_sb_size[w_idx] == xfer_size);
                w_fwd_data = r_sb_data[w_idx];
            end
        end
    end

    assign w_ld_elig = ~w_any_ovl;
    assign w_fwd_go  = w_ld_req & w_fwd_hit & ~r_load_valid &
                       ((r_state == S_IDLE) || (r_state == S_ST_BUSY));
`else
    assign w_ld_elig  = (r_count == '0);
    assign w_fwd_go   = 1'b0;
    assign w_fwd_data = '0;
`endif

    assign w_ld_issue = w_ld_req & ~r_load_valid & w_ld_elig;

    always_ff @(posedge clk) begin
        if (w_st_acc) begin
            r_sb_addr[r_tail] <= address;
            r_sb_data[r_tail] <= write_data;
            r_sb_size[r_tail] <= xfer_size;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_size   <= '0;
        end else begin
            r_load_valid <= 1'b0;
            if (w_fwd_go) begin
                r_load_valid <= 1'b1;
                r_load_data  <= mask_size(w_fwd_data, xfer_size);
            end
            if (w_st_acc && !w_st_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!w_st_acc && w_st_pop)
                r_count <= r_count - CNT_W'(1);
            if (w_st_acc)
                r_tail <= r_tail + PTR_W'(1);
            if (w_st_pop)
                r_head <= r_head + PTR_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_ld_issue) begin
                        r_state     <= S_LD_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= address;
                        r_mem_wdata <= '0;
                        r_mem_size  <= xfer_size;
                    end else if (r_count != '0) begin
                        r_state     <= S_ST_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_sb_addr[r_head];
                        r_mem_wdata <= r_sb_data[r_head];
                        r_mem_size  <= r_sb_size[r_head];
                    end else if (w_st_acc) begin
                        // Empty buffer: issue straight from the incoming store (it lands at head)
                        r_state     <= S_ST_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= address;
                        r_mem_wdata <= write_data;
                        r_mem_size  <= xfer_size;
                    end
                end
                S_ST_BUSY: begin
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                S_LD_BUSY: begin
                    if (mem_ack) begin
                        r_state      <= S_LD_DONE;
                        r_mem_req    <= 1'b0;
                        r_load_valid <= 1'b1;
                        r_load_data  <= mask_size(mem_rdata, r_mem_size);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_valid = r_load_valid;
    assign load_data  = r_load_data;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_size   = r_mem_size;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (default build, SB_DEPTH=4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write;
    logic [3:0]  xfer_size;
    logic [63:0] address, write_data;
    logic        zero, branch, cbz, cbnz;
    logic        BrTaken, stall, misalign, load_valid;
    logic [63:0] load_data;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [3:0]  mem_size;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic auto_ack, man_ack;
    int   n_assert = 0;
    int   n_fail   = 0;

    int          wr_cnt = 0, rd_cnt = 0, req_cyc = 0, rd_wr_seen = 0;
    logic [63:0] wr_addr_log [64];
    logic [63:0] wr_data_log [64];
    logic [63:0] rd_addr_last;

    always #5 clk = ~clk;

    always_comb mem_ack = auto_ack ? mem_req : man_ack;

    mem_access_unit #(.DATA_W(64), .ADDR_W(64), .SB_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .xfer_size(xfer_size),
        .address(address), .write_data(write_data),
        .zero(zero), .branch(branch), .cbz(cbz), .cbnz(cbnz),
        .BrTaken(BrTaken), .stall(stall), .misalign(misalign),
        .load_valid(load_valid), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Memory-side monitor: logs completed transfers
    always @(posedge clk) begin
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                wr_addr_log[wr_cnt[5:0]] <= mem_addr;
                wr_data_log[wr_cnt[5:0]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_addr_last <= mem_addr;
                rd_wr_seen   <= wr_cnt;
                rd_cnt       <= rd_cnt + 1;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic present_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; address = a; write_data = d; xfer_size = s;
        #1;
        n = 0;
        while (stall && n < 50) begin
            @(negedge clk); #1; n++;
        end
        n_assert++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL store_accept addr=%h: stall=%b, required 0", a, stall);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 0; req_write = 0; xfer_size = 4'd8; address = '0; write_data = '0;
        zero = 0; branch = 0; cbz = 0; cbnz = 0; auto_ack = 0; man_ack = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        n_assert += 7;
        if (mem_req !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
        if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        if (load_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_load_valid got %b want 0", load_valid); end
        if (load_data !== 64'h0)  begin n_fail++; $display("FAIL rst_load_data got %h want 0", load_data); end
        if (mem_addr !== 64'h0)   begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        if (mem_size !== 4'h0)    begin n_fail++; $display("FAIL rst_mem_size got %h want 0", mem_size); end
        if (stall !== 1'b0)       begin n_fail++; $display("FAIL rst_stall got %b want 0", stall); end
        reset_n = 1'b1;
    endtask

    task automatic test_branch();
        logic [3:0] vec [4];   // {branch, cbz, cbnz, zero}
        logic       exp [4];
        vec[0] = 4'b0010; exp[0] = 1'b1;
        vec[1] = 4'b0100; exp[1] = 1'b0;
        vec[2] = 4'b0101; exp[2] = 1'b1;
        vec[3] = 4'b1001; exp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {branch, cbz, cbnz, zero} = vec[i];
            #1;
            n_assert++;
            if (BrTaken !== exp[i]) begin
                n_fail++; $display("FAIL branch_%0d got %b want %b", i, BrTaken, exp[i]);
            end
        end
        {branch, cbz, cbnz, zero} = 4'b0000;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        req_valid = 1; req_write = 1; xfer_size = 4'd4; address = 64'h6; write_data = 64'hDEAD;
        #1;
        n_assert += 2;
        if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_4_6 got %b want 1", misalign); end
        if (stall !== 1'b0)    begin n_fail++; $display("FAIL misalign_stall got %b want 0", stall); end
        repeat (2) begin
            @(posedge clk); #1;
            n_assert++;
            if (mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_no_req got %b want 0", mem_req); end
        end
        xfer_size = 4'd3; address = 64'h0;
        #1;
        n_assert++;
        if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_size3 got %b want 1", misalign); end
        xfer_size = 4'd4; address = 64'h8;
        #1;
        n_assert++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL aligned_4_8 got %b want 0", misalign); end
        req_valid = 0; req_write = 0;
    endtask

    task automatic test_store_load();
        int w0, r0, n;
        w0 = wr_cnt; r0 = rd_cnt;
        auto_ack = 1;
        mem_rdata = 64'h1122_3344_5566_7788;
        present_store(64'h10, 64'hA0A0_0000_0000_0010, 4'd8);
        n_assert += 2;
        if (mem_req !== 1'b1)     begin n_fail++; $display("FAIL st_issue_req got %b want 1", mem_req); end
        if (mem_addr !== 64'h10)  begin n_fail++; $display("FAIL st_issue_addr got %h want 10", mem_addr); end
        present_store(64'h18, 64'hB0B0_0000_0000_0018, 4'd8);
        present_store(64'h20, 64'hC0C0_0000_0000_0020, 4'd8);
        @(negedge clk);
        req_valid = 1; req_write = 0; address = 64'h18; xfer_size = 4'd8;
        #1;
        n_assert++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall got %b want 1", stall); end
        n = 0;
        while (load_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        n_assert += 9;
        if (load_valid !== 1'b1)  begin n_fail++; $display("FAIL ld_valid_timeout got %b want 1", load_valid); end
        if (stall !== 1'b0)       begin n_fail++; $display("FAIL ld_done_stall got %b want 0", stall); end
        req_valid = 0;
        if (load_data !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL ld_data got %h want 1122334455667788", load_data); end
        if (wr_cnt - w0 !== 3)    begin n_fail++; $display("FAIL wr_count got %0d want 3", wr_cnt - w0); end
        if (wr_addr_log[w0[5:0]] !== 64'h10)      begin n_fail++; $display("FAIL wr0_addr got %h want 10", wr_addr_log[w0[5:0]]); end
        if (wr_addr_log[6'(w0 + 1)] !== 64'h18)   begin n_fail++; $display("FAIL wr1_addr got %h want 18", wr_addr_log[6'(w0 + 1)]); end
        if (wr_addr_log[6'(w0 + 2)] !== 64'h20)   begin n_fail++; $display("FAIL wr2_addr got %h want 20", wr_addr_log[6'(w0 + 2)]); end
        if (rd_cnt - r0 !== 1 || rd_addr_last !== 64'h18) begin
            n_fail++; $display("FAIL rd_issue got cnt=%0d addr=%h want cnt=1 addr=18", rd_cnt - r0, rd_addr_last);
        end
        if (rd_wr_seen - w0 !== 3) begin n_fail++; $display("FAIL rd_after_wr got %0d want 3", rd_wr_seen - w0); end
        n_assert++;
        if (wr_data_log[6'(w0 + 1)] !== 64'hB0B0_0000_0000_0018) begin
            n_fail++; $display("FAIL wr1_data got %h want b0b0000000000018", wr_data_log[6'(w0 + 1)]);
        end
    endtask

    task automatic test_zero_ext();
        auto_ack = 1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFAB;
        repeat (3) @(negedge clk);
        req_valid = 1; req_write = 0; address = 64'h33; xfer_size = 4'd1;
        @(posedge clk); #1;
        n_assert += 3;
        if (mem_req !== 1'b1)  begin n_fail++; $display("FAIL ld1_req got %b want 1", mem_req); end
        if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL ld1_we got %b want 0", mem_we); end
        if (mem_size !== 4'd1) begin n_fail++; $display("FAIL ld1_size got %0d want 1", mem_size); end
        @(posedge clk); #1;
        n_assert += 3;
        if (load_valid !== 1'b1)  begin n_fail++; $display("FAIL ld1_valid got %b want 1", load_valid); end
        if (load_data !== 64'hAB) begin n_fail++; $display("FAIL ld1_zext got %h want ab", load_data); end
        if (stall !== 1'b0)       begin n_fail++; $display("FAIL ld1_stall got %b want 0", stall); end
        req_valid = 0;
        @(posedge clk); #1;
        n_assert++;
        if (load_valid !== 1'b0)  begin n_fail++; $display("FAIL ld1_pulse got %b want 0", load_valid); end
    endtask

    task automatic test_full();
        auto_ack = 0; man_ack = 0;
        present_store(64'h40, 64'h40, 4'd8);
        present_store(64'h48, 64'h48, 4'd8);
        present_store(64'h50, 64'h50, 4'd8);
        present_store(64'h58, 64'h58, 4'd8);
        @(negedge clk);
        req_valid = 1; req_write = 1; address = 64'h60; write_data = 64'h60; xfer_size = 4'd8;
        #1;
        n_assert++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b want 1", stall); end
        man_ack = 1;
        #1;
        n_assert++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall_ack got %b want 1", stall); end
        @(posedge clk); #1;
        man_ack = 0;
        n_assert += 2;
        if (stall !== 1'b0)   begin n_fail++; $display("FAIL full_release got %b want 0", stall); end
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_gap got %b want 0", mem_req); end
        @(posedge clk); #1;
        req_valid = 0; req_write = 0;
        n_assert += 3;
        if (mem_req !== 1'b1)    begin n_fail++; $display("FAIL full_next_req got %b want 1", mem_req); end
        if (mem_we !== 1'b1)     begin n_fail++; $display("FAIL full_next_we got %b want 1", mem_we); end
        if (mem_addr !== 64'h48) begin n_fail++; $display("FAIL full_next_addr got %h want 48", mem_addr); end
    endtask

    task automatic test_reset_mid();
        int w0, q0;
        auto_ack = 0; man_ack = 0;
        apply_reset();
        present_store(64'h100, 64'h1, 4'd8);
        present_store(64'h108, 64'h2, 4'd8);
        n_assert += 2;
        if (mem_req !== 1'b1)     begin n_fail++; $display("FAIL rm_req got %b want 1", mem_req); end
        if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL rm_addr got %h want 100", mem_addr); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_assert += 3;
        if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL rm_async_req got %b want 0", mem_req); end
        if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL rm_async_we got %b want 0", mem_we); end
        if (mem_addr !== 64'h0) begin n_fail++; $display("FAIL rm_async_addr got %h want 0", mem_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        auto_ack = 1;
        w0 = wr_cnt; q0 = req_cyc;
        repeat (8) @(negedge clk);
        n_assert++;
        if (req_cyc !== q0) begin n_fail++; $display("FAIL rm_no_write got %0d req cycles want 0", req_cyc - q0); end
        present_store(64'h200, 64'h3, 4'd8);
        repeat (3) @(negedge clk);
        n_assert += 2;
        if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL rm_new_wr got %0d want 1", wr_cnt - w0); end
        if (wr_addr_log[w0[5:0]] !== 64'h200) begin
            n_fail++; $display("FAIL rm_new_addr got %h want 200", wr_addr_log[w0[5:0]]);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_misalign();
        test_store_load();
        test_zero_ext();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access stage that replaces the single-cycle data memory stage for variable-latency memory. It sits between EX and WB. It resolves the branch decision (CBZ and CBNZ), buffers stores in a SB_DEPTH-entry FIFO that drains in the background, and runs loads over a req/ack memory port. `stall` freezes the upstream pipeline while a load or a full store buffer is pending.

## Interface
- DATA_W, 64: data width in bits; must be 64 (max transfer 8 bytes).
- ADDR_W, 64: address width.
- SB_DEPTH, 4: store-buffer entries, power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  EX presents a memory op this cycle.
- req_write  in  1  1 = store, 0 = load (valid only with req_valid).
- xfer_size  in  4  bytes: 1, 2, 4 or 8; other values are treated as misaligned.
- address  in  ADDR_W  byte address (ALU result).
- write_data  in  DATA_W  store data, low xfer_size bytes used.
- zero, branch, cbz, cbnz  in  1  ALU zero flag and branch controls.
- BrTaken  out  1  branch | (cbz & zero) | (cbnz & ~zero), combinational.
- stall  out  1  hold EX request and upstream stages.
- misalign  out  1  address not a multiple of xfer_size (or illegal size) while req_valid; combinational.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- load_data  out  DATA_W  loaded value, zero-extended.
- mem_req, mem_we  out  1  memory request / write.
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_size  out  4.
- mem_ack  in  1  request complete at this edge.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

## Operation
- **Misaligned request:** the request is not accepted. `stall` = 0, and no state changes.
- **Store acceptance:** a store is accepted when req_valid & req_write & ~misalign & count < SB_DEPTH. The entry (addr, data, size) is written at the tail.
  - If count == SB_DEPTH, `stall` = 1. A retiring store in the same cycle does not free the slot until the next cycle.
- **Store-buffer count:**
  - +1 on store accept.
  - −1 on mem_ack of a store.
  - Both in the same cycle: count unchanged.
  - Pointers wrap modulo SB_DEPTH.
- **FSM states:**
  - IDLE: if a load is waiting and is eligible → LD_BUSY. Else if count > 0 → ST_BUSY (head entry).
  - ST_BUSY: mem_req=1, mem_we=1, fields from head. On mem_ack, pop the head → IDLE.
  - LD_BUSY: mem_req=1, mem_we=0. On mem_ack, register mem_rdata masked to xfer_size → LD_DONE.
  - LD_DONE: load_valid=1 for exactly one cycle → IDLE.
- **Load eligibility (base build):** count == 0 and state IDLE. Loads never bypass buffered stores.
- **Load stall:** `stall` = 1 from the first cycle a load is presented until the cycle before LD_DONE. `stall` = 0 in LD_DONE, and the load is consumed in that cycle.
- **Memory port rule:** mem_addr, mem_wdata, mem_size and mem_we are stable while mem_req=1. A mem_ack is ignored when mem_req=0.
- **Reset:** the buffer is emptied and pending stores are discarded.

## Timing
- **Reset values:** state IDLE, count 0, mem_req 0, mem_we 0, load_valid 0, load_data 0, mem_addr/mem_wdata/mem_size 0. Outputs are driven from registers, so they clear immediately on reset_n=0.
- **Store issue:** a store accepted at edge N can drive mem_req from cycle N+1.
- **Load, empty buffer, mem_ack in the first request cycle:** load presented in cycle 0 → mem_req in cycle 1 → load_valid in cycle 2.
- **Load latency in general:** 2 + (mem_ack wait cycles) + (store drain time).
- **Sequencing:** there is one outstanding memory request at a time. mem_req deasserts for at least one cycle between requests (the IDLE visit).

## Configuration
- **STORE_FWD_EN defined:** a load whose youngest overlapping buffer entry has an identical address and xfer_size is served from that entry. In that case load_valid=1 one cycle after presentation, with no memory request, and background draining continues.
  - Any other overlap falls back to full drain.
  - A load with no overlap may issue once the current store request completes, without waiting for count == 0.
- **STORE_FWD_EN undefined:** the base eligibility rule applies.

## Test plan
- **Branch:** cbnz=1, zero=0 → BrTaken=1. cbz=1, zero=0, branch=0 → BrTaken=0.
- **Three stores then load:**
  - Stimulus: 3 stores (8-byte, addr 0x10/0x18/0x20), mem_ack on the first request cycle; then a load of 0x18.
  - Base build: 3 write requests, then a read; load_valid with the mem_rdata value.
  - STORE_FWD_EN build: load_valid one cycle later with data from the 0x18 entry, and no read issued.
- **Full buffer:** with SB_DEPTH=4 and mem_ack held 0, a 5th store sees stall=1. A single mem_ack drops stall the next cycle.
- **Misaligned access:** xfer_size=4, address 0x6 → misalign=1, stall=0, count unchanged.
- **Zero-extension:** 1-byte load with mem_rdata=0xFFFF_FFFF_FFFF_FFAB → load_data=0xAB.
- **Reset mid-operation:** reset_n low during ST_BUSY with count=2 → mem_req=0 immediately, count 0. No write after release until a new store is accepted.
